serial_magnitude_comparator: RTL and testbench

Bit-serial unsigned magnitude comparator. Accepts two WIDTH-bit operands through a valid/ready handshake and scans them MSB-first, one bit per clock, through a 1-bit compare cell. It stops at the first differing bit and presents the greater/equal/less result on a valid/ready output port. It is the sequential, multi-bit consumer of the team's single-bit compare function, and serves datapaths where area matters more than latency.

---
 rtl/serial_magnitude_comparator_pkg.sv | 18 +
 rtl/serial_magnitude_comparator_if.sv | 27 ++
 rtl/serial_magnitude_comparator_bit_cmp_cell.sv | 15 +
 rtl/serial_magnitude_comparator.sv | 92 +++++++++
 tb/tb_serial_magnitude_comparator.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: FSM states and
// the width limit, plus the counter-width helper that the top module uses.
package comparator_pkg;

  localparam int CMP_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } cmp_state_t;

  // $clog2(1) is 0, so a one-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Operand and result handshake bundle for the serial magnitude comparator.
// The master side is the producer/consumer; the slave side is the comparator.
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             agb;
  logic             aeb;
  logic             alb;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, agb, aeb, alb
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, agb, aeb, alb
  );

endinterface

// File: rtl/serial_magnitude_comparator_bit_cmp_cell.sv
// Single-bit unsigned compare cell: exactly one of gt/eq/lt is high for any
// pair of input bits.
module bit_cmp_cell (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic eq,
  output logic lt
);

  assign gt = a & ~b;
  assign eq = ~(a ^ b);
  assign lt = ~a & b;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator: scans both operands MSB-first
// through one compare cell and stops at the first differing bit.
module serial_magnitude_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  serial_magnitude_comparator_if.slave cmp,
  output logic                         busy
);

  localparam int CNT_W = cnt_width(WIDTH);

  cmp_state_t       state;
  cmp_state_t       next_state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CNT_W-1:0] cnt;
  logic             cell_gt;
  logic             cell_eq;
  logic             cell_lt;

  bit_cmp_cell u_cell (
    .a  (sa[WIDTH-1]),
    .b  (sb[WIDTH-1]),
    .gt (cell_gt),
    .eq (cell_eq),
    .lt (cell_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmp.in_valid) next_state = SHIFT;
      SHIFT:   if (!cell_eq || cnt == '0) next_state = DONE;
      DONE:    if (cmp.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operands only move while scanning; a resolved compare leaves them frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      cnt <= '0;
    end else if (state == IDLE && cmp.in_valid) begin
      sa  <= cmp.a;
      sb  <= cmp.b;
      cnt <= CNT_W'(WIDTH - 1);
    end else if (state == SHIFT && cell_eq && cnt != '0) begin
      sa  <= sa << 1;
      sb  <= sb << 1;
      cnt <= cnt - CNT_W'(1);
    end
  end

  // On an all-equal scan the cell reports eq with gt/lt low, so latching the
  // cell directly covers both the early-exit and the full-length cases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp.out_valid <= 1'b0;
      cmp.agb       <= 1'b0;
      cmp.aeb       <= 1'b0;
      cmp.alb       <= 1'b0;
    end else if (state == SHIFT && next_state == DONE) begin
      cmp.out_valid <= 1'b1;
      cmp.agb       <= cell_gt;
      cmp.aeb       <= cell_eq;
      cmp.alb       <= cell_lt;
    end else if (state == DONE && cmp.out_ready) begin
      cmp.out_valid <= 1'b0;
      cmp.agb       <= 1'b0;
      cmp.aeb       <= 1'b0;
      cmp.alb       <= 1'b0;
    end
  end

  assign cmp.in_ready = (state == IDLE);
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator: an 8-bit and a 1-bit
// instance share one stimulus path selected by use_w1.
module tb_serial_magnitude_comparator;

  logic       clk;
  logic       rst_n;
  logic       use_w1;
  logic       iv_drv;
  logic       ordy_drv;
  logic [7:0] a_drv;
  logic [7:0] b_drv;
  logic       busy8;
  logic       busy1;

  logic ir, ov, agb, aeb, alb, busy;

  int checks   = 0;
  int failures = 0;

  serial_magnitude_comparator_if #(.WIDTH(8)) if8 ();
  serial_magnitude_comparator_if #(.WIDTH(1)) if1 ();

  assign if8.in_valid  = iv_drv & ~use_w1;
  assign if8.a         = a_drv;
  assign if8.b         = b_drv;
  assign if8.out_ready = ordy_drv;
  assign if1.in_valid  = iv_drv & use_w1;
  assign if1.a         = a_drv[0:0];
  assign if1.b         = b_drv[0:0];
  assign if1.out_ready = ordy_drv;

  assign ir   = use_w1 ? if1.in_ready  : if8.in_ready;
  assign ov   = use_w1 ? if1.out_valid : if8.out_valid;
  assign agb  = use_w1 ? if1.agb       : if8.agb;
  assign aeb  = use_w1 ? if1.aeb       : if8.aeb;
  assign alb  = use_w1 ? if1.alb       : if8.alb;
  assign busy = use_w1 ? busy1         : busy8;

  serial_magnitude_comparator #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .cmp   (if8.slave),
    .busy  (busy8)
  );

  serial_magnitude_comparator #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .cmp   (if1.slave),
    .busy  (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         cyc;
    logic [2:0] flags;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Presents one operand pair, then counts cycles (cycle 1 = the one after the
  // accept edge) until out_valid shows; flags must read zero while waiting.
  task automatic applyStimulus(input logic w1, input logic [7:0] av, input logic [7:0] bv,
                               input logic rdy, input string tag, output int lat);
    logic zero_ok;
    use_w1 = w1;
    @(negedge clk);
    ordy_drv = rdy;
    a_drv    = av;
    b_drv    = bv;
    iv_drv   = 1'b1;
    checkOutput({tag, "_in_ready_pre"}, 32'(ir), 32'd1);
    @(posedge clk);
    @(negedge clk);
    iv_drv  = 1'b0;
    lat     = 1;
    zero_ok = 1'b1;
    while (!ov && lat < 20) begin
      if ({agb, aeb, alb} != 3'b000) zero_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_flags_zero_before_valid"}, 32'(zero_ok), 32'd1);
  endtask

  initial begin
    int lat;
    vecs[0] = '{8'h80, 8'h7F, 2, 3'b100};
    vecs[1] = '{8'h12, 8'h13, 9, 3'b001};
    vecs[2] = '{8'hA5, 8'hA5, 9, 3'b010};
    vecs[3] = '{8'h00, 8'h00, 9, 3'b010};
    vecs[4] = '{8'hFF, 8'hFF, 9, 3'b010};
    vecs[5] = '{8'h40, 8'h20, 3, 3'b100};
    vecs[6] = '{8'h01, 8'h02, 8, 3'b001};
    vecs[7] = '{8'hFF, 8'h00, 2, 3'b100};
    vecs[8] = '{8'h0F, 8'h10, 5, 3'b001};
    vecs[9] = '{8'h5A, 8'h58, 8, 3'b100};

    use_w1   = 1'b0;
    iv_drv   = 1'b0;
    ordy_drv = 1'b1;
    a_drv    = 8'h00;
    b_drv    = 8'h00;
    rst_n    = 1'b0;

    #12;
    checkOutput("reset_in_ready", 32'(ir), 32'd1);
    checkOutput("reset_outputs", {28'd0, ov, agb, aeb, alb}, 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(1'b0, vecs[i].a, vecs[i].b, 1'b1, tag, lat);
      checkOutput({tag, "_latency"}, 32'(lat), 32'(vecs[i].cyc));
      checkOutput({tag, "_flags"}, {29'd0, agb, aeb, alb}, {29'd0, vecs[i].flags});
      @(negedge clk);
      checkOutput({tag, "_in_ready_back"}, {30'd0, ir, ov}, 32'b10);
    end

    // Backpressure: result must hold while a stray in_valid pulse is ignored.
    applyStimulus(1'b0, 8'h40, 8'h20, 1'b0, "bp", lat);
    checkOutput("bp_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a_drv  = 8'h00;
        b_drv  = 8'hFF;
        iv_drv = 1'b1;
      end
      if (i == 2) iv_drv = 1'b0;
      checkOutput($sformatf("bp_hold%0d", i), {27'd0, ir, ov, agb, aeb, alb}, 32'b01100);
    end
    ordy_drv = 1'b1;
    @(negedge clk);
    checkOutput("bp_release", {30'd0, ir, ov}, 32'b10);
    @(negedge clk);
    checkOutput("bp_no_queued", {30'd0, busy, ov}, 32'b00);
    applyStimulus(1'b0, 8'h33, 8'h34, 1'b1, "bp_next", lat);
    checkOutput("bp_next_latency", 32'(lat), 32'd7);
    checkOutput("bp_next_flags", {29'd0, agb, aeb, alb}, 32'b001);
    @(negedge clk);

    // Reset while scanning.
    @(negedge clk);
    a_drv  = 8'h01;
    b_drv  = 8'h02;
    iv_drv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv_drv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_shift_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_shift_outputs", {26'd0, ir, ov, agb, aeb, alb, busy}, 32'b100000);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while holding a result.
    applyStimulus(1'b0, 8'hFF, 8'h00, 1'b0, "rst_done", lat);
    checkOutput("rst_done_flags", {28'd0, ov, agb, aeb, alb}, 32'b1100);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_done_outputs", {26'd0, ir, ov, agb, aeb, alb, busy}, 32'b100000);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'hFF, 8'h00, 1'b1, "post_rst", lat);
    checkOutput("post_rst_latency", 32'(lat), 32'd2);
    checkOutput("post_rst_flags", {29'd0, agb, aeb, alb}, 32'b100);
    @(negedge clk);

    // One-bit instance resolves in its first scan cycle.
    applyStimulus(1'b1, 8'h01, 8'h00, 1'b1, "w1_gt", lat);
    checkOutput("w1_gt_latency", 32'(lat), 32'd2);
    checkOutput("w1_gt_flags", {29'd0, agb, aeb, alb}, 32'b100);
    @(negedge clk);
    applyStimulus(1'b1, 8'h01, 8'h01, 1'b1, "w1_eq", lat);
    checkOutput("w1_eq_latency", 32'(lat), 32'd2);
    checkOutput("w1_eq_flags", {29'd0, agb, aeb, alb}, 32'b010);
    @(negedge clk);
    applyStimulus(1'b1, 8'h00, 8'h01, 1'b1, "w1_lt", lat);
    checkOutput("w1_lt_latency", 32'(lat), 32'd2);
    checkOutput("w1_lt_flags", {29'd0, agb, aeb, alb}, 32'b001);
    @(negedge clk);
    checkOutput("w1_in_ready_back", {30'd0, ir, ov}, 32'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
